// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged FIFO.
// Depth/count-width helpers and read-mode enum.
package fifo_pkg;

  typedef enum logic {
    READ_FWFT,
    READ_REGISTERED
  } read_mode_e;

  function automatic int depth_f(input int aw);
    return 1 << aw;
  endfunction

  function automatic int cnt_w_f(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_reg_file.sv
// Storage array for the flagged FIFO.
// Synchronous write, asynchronous read.
module fifo_reg_file
  import fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = depth_f(AW);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flagged.sv
// Circular-queue FIFO with count, threshold flags,
// sticky error flags, flush and FWFT/registered read.
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic [ADDR_WIDTH:0]   almost_full_th,
  input  logic [ADDR_WIDTH:0]   almost_empty_th,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam read_mode_e MODE =
    (FWFT != 0) ? READ_FWFT : READ_REGISTERED;
  localparam int CW = cnt_w_f(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(depth_f(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc, we;
  logic [DATA_WIDTH-1:0] mem_rd;

  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign almost_full  = (cnt_q >= almost_full_th);
  assign almost_empty = (cnt_q <= almost_empty_th);
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign wr_acc = wr && (!full || rd);
  assign rd_acc = rd && !empty;
  assign we     = wr_acc && !flush && reset;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      cnt_d   = '0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
      unique case (1'b1)
        (wr_acc && !rd_acc): cnt_d = cnt_q + 1'b1;
        (rd_acc && !wr_acc): cnt_d = cnt_q - 1'b1;
        default:             cnt_d = cnt_q;
      endcase
      // A new error beats a coincident clear
      ovf_d = (wr && full && !rd) ||
              (ovf_q && !clr_err);
      unf_d = (rd && empty) ||
              (unf_q && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_reg_file #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_rf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (w_ptr_q),
    .wdata_i (w_data),
    .raddr_i (r_ptr_q),
    .rdata_o (mem_rd)
  );

  generate
    if (MODE == READ_FWFT) begin : g_fwft
      assign r_data = empty ? '0 : mem_rd;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_acc && !flush) rdata_d = mem_rd;
      end

      always_ff @(posedge clk) begin
        if (!reset) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign r_data = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: FWFT and registered
// instances against a queue-based model.
module tb_fifo_flagged;

  logic       clk = 0;
  logic       reset, wr, rd, flush, clr_err;
  logic [7:0] w_data;
  logic [3:0] af_th, ae_th;

  logic [7:0] rd_f, rd_r;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic [3:0] cnt_f, cnt_r;

  int checks = 0;
  int failures = 0;
  bit en = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rreg;

  always #5 clk = ~clk;

  fifo_flagged #(.DATA_WIDTH(8), .ADDR_WIDTH(3),
                 .FWFT(1)) u_f (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_data(w_data), .flush(flush),
    .clr_err(clr_err),
    .almost_full_th(af_th),
    .almost_empty_th(ae_th),
    .r_data(rd_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f),
    .count(cnt_f), .overflow(ovf_f),
    .underflow(unf_f)
  );

  fifo_flagged #(.DATA_WIDTH(8), .ADDR_WIDTH(3),
                 .FWFT(0)) u_r (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd),
    .w_data(w_data), .flush(flush),
    .clr_err(clr_err),
    .almost_full_th(af_th),
    .almost_empty_th(ae_th),
    .r_data(rd_r), .full(full_r), .empty(empty_r),
    .almost_full(af_r), .almost_empty(ae_r),
    .count(cnt_r), .overflow(ovf_r),
    .underflow(unf_r)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: a queue and a few bits
  always @(posedge clk) begin
    bit wa, ra, no, nu;
    int n;
    n = mq.size();
    if (!reset) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_rreg = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      wa = wr && (n < 8 || rd);
      ra = rd && n > 0;
      no = wr && n == 8 && !rd;
      nu = rd && n == 0;
      if (ra) m_rreg = mq.pop_front();
      if (wa) mq.push_back(w_data);
      m_ovf = no || (m_ovf && !clr_err);
      m_unf = nu || (m_unf && !clr_err);
    end
  end

  always @(negedge clk) begin
    int n;
    logic [7:0] hd;
    if (en) begin
      n = mq.size();
      hd = (n > 0) ? mq[0] : 8'h0;
      chk("cnt_f", 32'(cnt_f), 32'(n));
      chk("cnt_r", 32'(cnt_r), 32'(n));
      chk("full_f", 32'(full_f), 32'(n == 8));
      chk("full_r", 32'(full_r), 32'(n == 8));
      chk("empty_f", 32'(empty_f), 32'(n == 0));
      chk("empty_r", 32'(empty_r), 32'(n == 0));
      chk("af_f", 32'(af_f), 32'(n >= int'(af_th)));
      chk("af_r", 32'(af_r), 32'(n >= int'(af_th)));
      chk("ae_f", 32'(ae_f), 32'(n <= int'(ae_th)));
      chk("ae_r", 32'(ae_r), 32'(n <= int'(ae_th)));
      chk("ovf_f", 32'(ovf_f), 32'(m_ovf));
      chk("ovf_r", 32'(ovf_r), 32'(m_ovf));
      chk("unf_f", 32'(unf_f), 32'(m_unf));
      chk("unf_r", 32'(unf_r), 32'(m_unf));
      chk("rdata_f", 32'(rd_f), 32'(hd));
      chk("rdata_r", 32'(rd_r), 32'(m_rreg));
    end
  end

  task automatic op(input bit w, input bit r,
                    input logic [7:0] d,
                    input bit fl = 0,
                    input bit cl = 0,
                    input bit rs = 1);
    wr = w;
    rd = r;
    w_data = d;
    flush = fl;
    clr_err = cl;
    reset = rs;
    @(posedge clk);
    #1;
    wr = 0;
    rd = 0;
    flush = 0;
    clr_err = 0;
    reset = 1;
  endtask

  initial begin
    logic [7:0] v1 [8];
    v1 = '{5, 8, 12, 2, 9, 14, 13, 6};
    reset = 0; wr = 0; rd = 0; flush = 0;
    clr_err = 0; w_data = 0;
    af_th = 6; ae_th = 1;
    op(0, 0, 0, 0, 0, 0);
    en = 1;
    op(0, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty_f), 1);
    chk("rst_ae", 32'(ae_f), 1);
    chk("rst_rdr", 32'(rd_r), 0);

    // 1: fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      op(1, 0, v1[i]);
      chk("fill_cnt", 32'(cnt_f), i + 1);
      chk("fill_af", 32'(af_f), 32'(i + 1 >= 6));
    end
    chk("fill_full", 32'(full_f), 1);
    op(1, 0, 7);
    chk("ovf_set", 32'(ovf_f), 1);
    chk("ovf_cnt", 32'(cnt_f), 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(rd_f), 32'(v1[i]));
      op(0, 1, 0);
      chk("drain_ae", 32'(ae_f), 32'(7 - i <= 1));
    end
    chk("drain_empty", 32'(empty_f), 1);

    // 2: underflow and clear
    op(0, 0, 0, 0, 1);
    op(0, 1, 0);
    chk("unf_set", 32'(unf_f), 1);
    chk("unf_cnt", 32'(cnt_f), 0);
    chk("unf_rdata", 32'(rd_f), 0);
    op(0, 0, 0, 0, 1);
    chk("unf_clr", 32'(unf_f), 0);

    // 3: wr&rd on empty
    op(1, 1, 17);
    chk("e_wr_rd_cnt", 32'(cnt_f), 1);
    chk("e_wr_rd_unf", 32'(unf_f), 1);
    chk("e_wr_rd_dat", 32'(rd_f), 17);
    op(0, 1, 0);
    chk("e_rd_r", 32'(rd_r), 17);
    op(0, 0, 0, 0, 1);

    // 4: wr&rd on full, wraps pointers
    for (int i = 0; i < 8; i++) op(1, 0, 8'(20 + i));
    op(1, 1, 99);
    chk("f_wr_rd_cnt", 32'(cnt_f), 8);
    chk("f_wr_rd_ovf", 32'(ovf_f), 0);
    chk("f_wr_rd_r", 32'(rd_r), 20);
    for (int i = 0; i < 7; i++) begin
      chk("f_old", 32'(rd_f), 32'(21 + i));
      op(0, 1, 0);
    end
    chk("f_new", 32'(rd_f), 99);
    op(0, 1, 0);

    // 5: registered read
    op(1, 0, 12); op(1, 0, 4); op(1, 0, 23);
    op(0, 1, 0);
    chk("reg_0", 32'(rd_r), 12);
    op(0, 1, 0);
    chk("reg_1", 32'(rd_r), 4);
    op(0, 1, 0);
    chk("reg_2", 32'(rd_r), 23);
    op(0, 0, 0);
    chk("reg_hold", 32'(rd_r), 23);

    // 6: flush and reset
    op(0, 1, 0);
    op(1, 0, 1); op(1, 0, 2); op(1, 0, 3);
    op(1, 1, 9, 1);
    chk("fl_cnt", 32'(cnt_f), 0);
    chk("fl_empty", 32'(empty_f), 1);
    chk("fl_unf", 32'(unf_f), 1);
    chk("fl_rdr", 32'(rd_r), 23);
    for (int i = 0; i < 5; i++) op(1, 0, 8'(40 + i));
    op(1, 1, 0, 1, 0, 0);
    chk("rs_cnt", 32'(cnt_f), 0);
    chk("rs_empty", 32'(empty_f), 1);
    chk("rs_unf", 32'(unf_f), 0);
    chk("rs_ovf", 32'(ovf_f), 0);
    op(1, 0, 11);
    chk("rs_wr_f", 32'(rd_f), 11);
    op(0, 1, 0);
    chk("rs_wr_r", 32'(rd_r), 11);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_th = 4'($urandom_range(0, 15));
        ae_th = 4'($urandom_range(0, 15));
      end
      op($urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1,
         8'($urandom),
         $urandom_range(0, 31) == 0,
         $urandom_range(0, 15) == 0,
         $urandom_range(0, 199) != 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Parametrised successor to the team's single-clock circular-queue FIFO.
- Adds the following on top of the basic full/empty FIFO:
  - occupancy count;
  - runtime-programmable almost-full and almost-empty thresholds;
  - sticky overflow and underflow error flags;
  - synchronous flush;
  - choice of first-word-fall-through (FWFT) or registered-read mode.
- Sits between producer and consumer blocks that need early back-pressure and error visibility.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, depth is 2**ADDR_WIDTH words.
- FWFT, 1, 1 = head word visible on r_data without a read; 0 = r_data registered, updated one cycle after an accepted read.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset: sampled at the rising edge of clk; 0 resets.
- wr  in  1  write request.
- rd  in  1  read request.
- w_data  in  DATA_WIDTH  write data.
- flush  in  1  synchronous empty-the-queue.
- clr_err  in  1  clears sticky error flags.
- almost_full_th  in  ADDR_WIDTH+1  almost_full asserted when count >= this value.
- almost_empty_th  in  ADDR_WIDTH+1  almost_empty asserted when count <= this value.
- r_data  out  DATA_WIDTH  read data.
- full  out  1  count == 2**ADDR_WIDTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  sticky: a write was attempted while full without a simultaneous read.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (reset==0 at the edge):
  - w_ptr, r_ptr and count go to 0; overflow and underflow go to 0.
  - Registered r_data goes to 0.
  - Storage contents are not cleared.
  - After reset: empty=1, full=0, almost_empty=1 iff almost_empty_th>=0 (always), almost_full=1 iff almost_full_th==0.
  - Reset overrides flush, wr and rd in the same cycle.
- Accepted write: wr && (!full || rd). Stores w_data at w_ptr; w_ptr increments modulo depth.
- Accepted read: rd && !empty. r_ptr increments modulo depth.
- Full plus simultaneous wr&&rd: both accepted, count unchanged.
- Empty plus simultaneous wr&&rd: write accepted, read rejected, underflow sets. No pass-through.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Status flags (full, empty, almost_full, almost_empty, count) are combinational from registered count and thresholds only. No combinational path from wr, rd or w_data.
- Error flags:
  - overflow sets on wr && full && !rd; the rejected word is dropped and no state changes.
  - underflow sets on rd && empty.
  - Both stay set until clr_err or reset. If clr_err coincides with a new error, the set wins.
- flush (reset==1): next edge sets pointers and count to 0.
  - wr and rd in the same cycle are ignored.
  - Error flags unchanged.
  - Registered r_data holds.
- FWFT=1:
  - r_data = mem[r_ptr] when !empty, 0 when empty.
  - An accepted read exposes the next word after the same edge.
  - The first write into an empty FIFO is visible on r_data the cycle after the write edge.
- FWFT=0:
  - r_data is loaded with mem[r_ptr] on the edge that accepts a read, so data is valid the cycle after rd is asserted.
  - Otherwise r_data holds.
- Wrap-around: pointers are ADDR_WIDTH bits and wrap naturally; count disambiguates full from empty.
- Threshold values above depth: almost_full never asserts; almost_empty always asserts.
- Thresholds may change at any time; flags follow combinationally.

Decomposition:
- Package fifo_pkg holds:
  - localparam helpers: depth function of ADDR_WIDTH, count width;
  - an enum for read mode (READ_FWFT, READ_REGISTERED) that the FWFT parameter maps onto.
- One sub-module, fifo_reg_file: 2**ADDR_WIDTH x DATA_WIDTH array with synchronous write and asynchronous read address port.
- Pointer, count, flag and error logic live in fifo_flagged.

Test Plan:
1. Fill and drain, FWFT=1, thresholds 6/1. Write 5,8,12,2,9,14,13,6 then attempt a write of 7.
   - Fill: count steps 1..8; almost_full at count 6; full at 8.
   - Write of 7 sets overflow, count stays 8.
   - Eight reads return 5,8,12,2,9,14,13,6 in order; empty=1 after the last; almost_empty at count<=1.
2. Read while empty: rd=1 one cycle on an empty FIFO.
   - underflow=1; count stays 0; r_data=0.
   - clr_err pulse then clears it to 0.
3. Simultaneous rd&wr when empty, write 17: count becomes 1, underflow=1, next read returns 17.
4. Simultaneous rd&wr when full: count stays 8, no overflow, head word returned; new word appears after the seven older ones; pointers wrap correctly past index 7.
5. FWFT=0: write 12,4,23, then rd pulses.
   - r_data = 12, 4, 23 each one cycle after its rd; r_data holds 23 afterwards.
6. Flush and reset mid-operation:
   - With count=3, flush gives count=0 and empty=1 with error flags preserved.
   - Refill to 5; reset=0 for one edge gives count=0, empty=1, overflow=underflow=0.
   - A subsequent write of 11 reads back 11.
